seven_seg_scan_driver: RTL and testbench
========================================

# seven_seg_scan_driver

Parametrised multiplexed seven-segment display driver. It takes NUM_DIGITS 5-bit glyph codes and scans them onto a common-anode display, one digit per refresh slot. It adds the following:
- a shadow register, so updates apply atomically at frame boundaries with no tearing
- per-digit decimal point and blanking
- anti-ghosting dead time at every slot start
- an explicit blank glyph

It sits between the AES top-level result/status logic and the board display pins.

## Interface
- NUM_DIGITS, 4, digits scanned (1..16)
- REFRESH_DIV, 100000, clocks per digit slot (≥ 4)
- GHOST_CYCLES, 2, slot-start clocks with all anodes off (1 ≤ GHOST_CYCLES < REFRESH_DIV)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  1 = scan; 0 = display dark
- load  in  1  capture digits_in/dp_in/blank_in into pending shadow
- digits_in  in  5*NUM_DIGITS  glyph codes; digit i at [5i+4:5i]; digit 0 rightmost
- dp_in  in  NUM_DIGITS  decimal point request per digit, active-high
- blank_in  in  NUM_DIGITS  force digit dark, active-high
- anode  out  NUM_DIGITS  digit select, active-low, one-hot-low or all-high
- cathode  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- digit_idx  out  clog2(NUM_DIGITS) (min 1)  index of digit currently driven
- frame_done  out  1  one-cycle pulse when scan wraps to digit 0

## Operation
- Glyph map, cathode hex:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78, 8:00, 9:10
  - A:08, b:03, C:46, d:21, E:06, F:0E
  - 0x10 "P":0C, 0x11 "-":3F
  - 0x12–0x1F: 7F (blank, not "0")
- Prescaler cnt counts 0..REFRESH_DIV-1. Digit index idx advances on cnt wrap and wraps from NUM_DIGITS-1 to 0.
- Frame boundary: the edge where cnt=REFRESH_DIV-1 and idx=NUM_DIGITS-1.
- Shadow path:
  - load=1 writes pending registers and sets pend_valid.
  - At a frame boundary with pend_valid, active ← pending and pend_valid clears.
  - load on the boundary edge itself: the load data go straight to active and pend_valid stays 0.
  - Multiple loads within one frame: the last one wins.
- Drive, when enable=1 and GHOST_CYCLES ≤ cnt:
  - anode[idx]=0, all others 1
  - cathode from active glyph[idx]
  - dp = ~active_dp[idx]
  - if active_blank[idx]: cathode=7F, dp=1, anode still asserted
- Drive when cnt < GHOST_CYCLES: anode all 1, cathode 7F, dp 1.
- enable=0:
  - cnt and idx are held at 0; outputs are dark.
  - loads are accepted, and pending transfers to active on the next edge (no frame wait).
  - frame_done stays 0.
- Resuming from enable=0: scanning restarts at digit 0, cnt 0.

## Timing
- All outputs registered. anode/cathode/dp/digit_idx reflect the cnt/idx/active state of the previous cycle (1-clock latency).
- frame_done is high for exactly the one cycle in which digit_idx first reads 0 of a new frame. It never fires during reset or while disabled.
- Per slot: GHOST_CYCLES cycles dark, then REFRESH_DIV-GHOST_CYCLES cycles lit.
- Frame period: NUM_DIGITS*REFRESH_DIV cycles.
- Reset (asynchronous, effective immediately):
  - outputs: anode all 1, cathode 7F, dp 1, digit_idx 0, frame_done 0
  - state: cnt 0, idx 0, pend_valid 0
  - active and pending glyphs 0x12 (blank), dp/blank registers 0
- Reset mid-scan: the display goes dark within the same cycle. After release, scanning restarts from digit 0 with blank content until a load is committed.
- NUM_DIGITS=1: idx is always 0, and every slot wrap is a frame boundary.

## Test plan
Default configuration for all scenarios: NUM_DIGITS=4, REFRESH_DIV=8, GHOST_CYCLES=2.
- Reset, then enable=1, no load:
  - the anode sequence cycles E,D,B,7 every 8 clocks, with all-F for the first 2 clocks of each slot.
  - cathode stays 7F throughout.
  - frame_done pulses every 32 clocks.
- Commit and display a load:
  - Stimulus: load digits {0x0F,0x0A,0x01,0x00} (d3..d0) with dp_in=4'b0010 mid-frame.
  - No change until the next frame_done.
  - Then d0 shows cathode 40, d1 shows 79 with dp=0, d2 shows 08, d3 shows 0E.
- Load-wins and coincident-load rules:
  - Two loads in one frame (0x11 ×4, then 0x10 ×4): only "P" (0C) appears.
  - A load on the exact boundary edge appears in the frame that starts on that edge.
- Blank handling:
  - blank_in=4'b0100 with glyph 8 everywhere: d2 has anode low but cathode 7F and dp 1; the other digits show 00.
  - Glyph codes 0x12 and 0x1F both show 7F.
- enable=0 mid-slot: the next-cycle outputs are dark and digit_idx=0.
  - A load while disabled commits without waiting for a frame.
  - Re-enable: d0 is lit after 2 dead clocks (+1 register latency).
- Reset during the lit d2 slot:
  - same-cycle dark outputs.
  - after release, restart at d0 with blank content and pend_valid cleared.

Source files
------------

// File: rtl/seven_seg_scan_driver_if.sv
// Bus bundle between the display driver and whatever feeds it glyphs.
// The master side supplies content; the slave side drives the pins.
interface seven_seg_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    enable;
    logic                    load;
    logic [5*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic [NUM_DIGITS-1:0]   anode;
    logic [6:0]              cathode;
    logic                    dp;
    logic [IDX_W-1:0]        digit_idx;
    logic                    frame_done;

    modport master (
        output enable, load, digits_in, dp_in, blank_in,
        input  anode, cathode, dp, digit_idx, frame_done
    );

    modport slave (
        input  enable, load, digits_in, dp_in, blank_in,
        output anode, cathode, dp, digit_idx, frame_done
    );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed common-anode seven-segment scanner with a frame-atomic
// shadow register, per-digit dp/blank and slot-start anti-ghost dead time.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int GHOST_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    seven_seg_scan_driver_if.slave   bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(REFRESH_DIV);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GHOST    = CNT_W'(GHOST_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [4:0]       BLANK    = 5'h12;
    localparam logic [6:0]       DARK     = 7'h7F;

    logic [CNT_W-1:0]               cnt;
    logic [IDX_W-1:0]               idx;
    logic [NUM_DIGITS-1:0][4:0]     pend_glyph;
    logic [NUM_DIGITS-1:0][4:0]     act_glyph;
    logic [NUM_DIGITS-1:0]          pend_dp;
    logic [NUM_DIGITS-1:0]          pend_blank;
    logic [NUM_DIGITS-1:0]          act_dp;
    logic [NUM_DIGITS-1:0]          act_blank;
    logic                           pend_valid;
    logic                           wrap_q;

    logic                           slot_end;
    logic                           boundary;
    logic                           commit;
    logic                           lit;
    logic                           show;
    logic [NUM_DIGITS-1:0]          next_anode;
    logic [6:0]                     next_cathode;
    logic                           next_dp;
    logic [IDX_W-1:0]               next_idx;

    function automatic logic [6:0] glyph_seg(input logic [4:0] code);
        logic [6:0] seg;
        case (code)
            5'h00:   seg = 7'h40;
            5'h01:   seg = 7'h79;
            5'h02:   seg = 7'h24;
            5'h03:   seg = 7'h30;
            5'h04:   seg = 7'h19;
            5'h05:   seg = 7'h12;
            5'h06:   seg = 7'h02;
            5'h07:   seg = 7'h78;
            5'h08:   seg = 7'h00;
            5'h09:   seg = 7'h10;
            5'h0A:   seg = 7'h08;
            5'h0B:   seg = 7'h03;
            5'h0C:   seg = 7'h46;
            5'h0D:   seg = 7'h21;
            5'h0E:   seg = 7'h06;
            5'h0F:   seg = 7'h0E;
            5'h10:   seg = 7'h0C;
            5'h11:   seg = 7'h3F;
            default: seg = DARK;
        endcase
        return seg;
    endfunction

    assign slot_end = (cnt == CNT_LAST);
    assign boundary = bus.enable && slot_end && (idx == IDX_LAST);
    // While dark there is no frame to tear, so content commits at once.
    assign commit   = bus.enable ? boundary : 1'b1;

    // Prescaler and digit index; both parked at 0 while disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (!bus.enable) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Shadow path: a load on the commit edge bypasses pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_glyph <= {NUM_DIGITS{BLANK}};
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_valid <= 1'b0;
            act_glyph  <= {NUM_DIGITS{BLANK}};
            act_dp     <= '0;
            act_blank  <= '0;
        end else begin
            if (bus.load) begin
                pend_glyph <= bus.digits_in;
                pend_dp    <= bus.dp_in;
                pend_blank <= bus.blank_in;
            end
            if (commit && bus.load) begin
                act_glyph  <= bus.digits_in;
                act_dp     <= bus.dp_in;
                act_blank  <= bus.blank_in;
                pend_valid <= 1'b0;
            end else if (commit && pend_valid) begin
                act_glyph  <= pend_glyph;
                act_dp     <= pend_dp;
                act_blank  <= pend_blank;
                pend_valid <= 1'b0;
            end else if (bus.load) begin
                pend_valid <= 1'b1;
            end
        end
    end

    // Next pin values from the current slot position and active content.
    always_comb begin
        lit          = bus.enable && (cnt >= GHOST);
        show         = lit && !act_blank[idx];
        next_anode   = '1;
        next_cathode = DARK;
        next_dp      = 1'b1;
        next_idx     = '0;
        if (lit) begin
            next_anode = ~(NUM_DIGITS'(1) << idx);
        end
        if (show) begin
            next_cathode = glyph_seg(act_glyph[idx]);
            next_dp      = ~act_dp[idx];
        end
        if (bus.enable) begin
            next_idx = idx;
        end
    end

    // Output registers; frame_done trails the wrap by one edge so it
    // lines up with digit_idx first reading 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.anode      <= '1;
            bus.cathode    <= DARK;
            bus.dp         <= 1'b1;
            bus.digit_idx  <= '0;
            bus.frame_done <= 1'b0;
            wrap_q         <= 1'b0;
        end else begin
            bus.anode      <= next_anode;
            bus.cathode    <= next_cathode;
            bus.dp         <= next_dp;
            bus.digit_idx  <= next_idx;
            bus.frame_done <= wrap_q && bus.enable;
            wrap_q         <= boundary;
        end
    end
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver (4 digits, 8 clocks/slot,
// 2 dead clocks) covering scan timing, shadow commits, blanking, enable, reset.
module tb_seven_seg_scan_driver;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   k = 0;

    logic [6:0] ecat [4];
    logic [3:0] edp;
    logic [3:0] eblank;

    seven_seg_scan_driver_if #(.NUM_DIGITS(4)) bus ();

    seven_seg_scan_driver #(
        .NUM_DIGITS(4),
        .REFRESH_DIV(8),
        .GHOST_CYCLES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s k=%0d: got %h expected %h", tag, k, got, exp);
        end
    endtask

    task automatic set_exp(input logic [27:0] cats, input logic [3:0] dps,
                           input logic [3:0] bls);
        for (int i = 0; i < 4; i++) ecat[i] = cats[7*i +: 7];
        edp    = dps;
        eblank = bls;
    endtask

    task automatic do_load(input logic [19:0] d, input logic [3:0] dpv,
                           input logic [3:0] bl);
        bus.load      = 1'b1;
        bus.digits_in = d;
        bus.dp_in     = dpv;
        bus.blank_in  = bl;
    endtask

    task automatic check_dark(input string tag);
        chk({tag, "_anode"}, 32'(bus.anode), 32'hF);
        chk({tag, "_cathode"}, 32'(bus.cathode), 32'h7F);
        chk({tag, "_dp"}, 32'(bus.dp), 32'h1);
        chk({tag, "_idx"}, 32'(bus.digit_idx), 32'h0);
        chk({tag, "_fdone"}, 32'(bus.frame_done), 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One scanning clock, checked against the expected slot position.
    task automatic tick();
        int c;
        int i;
        logic lit;
        logic [3:0] an;
        logic [6:0] cat;
        logic d;
        step();
        k++;
        c   = (k - 1) % 8;
        i   = ((k - 1) / 8) % 4;
        lit = (c >= 2);
        an  = lit ? ~(4'b0001 << i) : 4'hF;
        cat = (lit && !eblank[i]) ? ecat[i] : 7'h7F;
        d   = (lit && !eblank[i]) ? ~edp[i] : 1'b1;
        chk("anode", 32'(bus.anode), 32'(an));
        chk("cathode", 32'(bus.cathode), 32'(cat));
        chk("dp", 32'(bus.dp), 32'(d));
        chk("digit_idx", 32'(bus.digit_idx), i);
        chk("frame_done", 32'(bus.frame_done),
            32'((k > 1) && ((k - 1) % 32 == 0)));
    endtask

    task automatic run_until(input int target);
        while (k < target) tick();
    endtask

    localparam logic [27:0] ALL_DARK = {4{7'h7F}};

    logic [19:0] ent_d [5];
    logic [27:0] ent_c [5];
    logic [3:0]  ent_p [5];

    initial begin
        int base;
        ent_d[0] = {5'h1F, 5'h12, 5'h1F, 5'h12};
        ent_c[0] = ALL_DARK;
        ent_p[0] = 4'b0000;
        ent_d[1] = {5'h06, 5'h05, 5'h04, 5'h03};
        ent_c[1] = {7'h02, 7'h12, 7'h19, 7'h30};
        ent_p[1] = 4'b1001;
        ent_d[2] = {5'h0C, 5'h0B, 5'h09, 5'h07};
        ent_c[2] = {7'h46, 7'h03, 7'h10, 7'h78};
        ent_p[2] = 4'b0000;
        ent_d[3] = {5'h11, 5'h10, 5'h0E, 5'h0D};
        ent_c[3] = {7'h3F, 7'h0C, 7'h06, 7'h21};
        ent_p[3] = 4'b0110;
        ent_d[4] = {5'h02, 5'h0F, 5'h0A, 5'h01};
        ent_c[4] = {7'h24, 7'h0E, 7'h08, 7'h79};
        ent_p[4] = 4'b0000;

        reset         = 1'b1;
        bus.enable    = 1'b0;
        bus.load      = 1'b0;
        bus.digits_in = '0;
        bus.dp_in     = '0;
        bus.blank_in  = '0;
        set_exp(ALL_DARK, 4'b0000, 4'b0000);

        step();
        check_dark("reset");
        step();
        reset      = 1'b0;
        bus.enable = 1'b1;
        k          = 0;

        // Blank scan after reset: two full frames plus a bit.
        run_until(66);

        // Mid-frame load waits for the frame boundary at k=96.
        do_load({5'h0F, 5'h0A, 5'h01, 5'h00}, 4'b0010, 4'b0000);
        tick();
        bus.load = 1'b0;
        run_until(96);
        set_exp({7'h0E, 7'h08, 7'h79, 7'h40}, 4'b0010, 4'b0000);
        run_until(130);

        // Two loads in one frame: the second wins.
        do_load({4{5'h11}}, 4'b0000, 4'b0000);
        tick();
        bus.load = 1'b0;
        run_until(140);
        do_load({4{5'h10}}, 4'b0000, 4'b0000);
        tick();
        bus.load = 1'b0;
        run_until(160);
        set_exp({4{7'h0C}}, 4'b0000, 4'b0000);

        // Load exactly on the boundary edge (k=192), with d2 blanked.
        run_until(191);
        do_load({4{5'h08}}, 4'b0000, 4'b0100);
        tick();
        bus.load = 1'b0;
        set_exp({4{7'h00}}, 4'b0000, 4'b0100);

        // Glyph table sweep, each entry committed at the next boundary.
        base = 192;
        for (int j = 0; j < 5; j++) begin
            run_until(base + 4);
            do_load(ent_d[j], ent_p[j], 4'b0000);
            tick();
            bus.load = 1'b0;
            run_until(base + 32);
            set_exp(ent_c[j], ent_p[j], 4'b0000);
            base += 32;
        end
        run_until(404);

        // Disable in the middle of the lit d2 slot.
        bus.enable = 1'b0;
        step();
        check_dark("disable");
        do_load({4{5'h08}}, 4'b1111, 4'b0000);
        step();
        bus.load = 1'b0;
        step();
        check_dark("disabled_load");
        step();
        check_dark("disabled_hold");

        // Re-enable: restart at d0 showing the load committed while dark.
        bus.enable = 1'b1;
        k          = 0;
        set_exp({4{7'h00}}, 4'b1111, 4'b0000);
        run_until(17);
        do_load({4{5'h01}}, 4'b0000, 4'b0000);
        tick();
        bus.load = 1'b0;
        run_until(20);

        // Asynchronous reset during the lit d2 slot.
        #2;
        reset = 1'b1;
        #1;
        check_dark("async_reset");
        step();
        check_dark("reset_hold");
        reset = 1'b0;
        k     = 0;
        set_exp(ALL_DARK, 4'b0000, 4'b0000);
        run_until(70);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
